lampfpu_log_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one bfloat16 log unit (`lampFPU_log`) among `NREQ` independent requesters. It accepts classified operands over valid/ready handshakes and issues at most one operation per cycle into the unit. It tracks each operation's owner through the unit's fixed latency and returns each result to the owning requester through a one-entry, back-pressurable result buffer. It sits between the FPU issue logic and the log datapath and needs no changes to the datapath.

---
 rtl/lampfpu_log_arb_pkg.sv | 31 +++
 rtl/lampfpu_log_rr_pick.sv | 49 ++++
 rtl/lampfpu_log_arb.sv | 160 ++++++++++++++++
 tb/tb_lampfpu_log_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lampfpu_log_arb_pkg.sv
// lampfpu_log_arb_pkg
// Shared types and constants for the log-unit arbiter slice.
//   lampLogOp_t  : operand bundle presented to the log unit (20 bits)
//   lampLogRes_t : result bundle returned by the log unit (19 bits)
//   LAMP_LOG_LAT : cycles from doLog_i to valid_o in lampFPU_log
package lampfpu_log_arb_pkg;

    localparam int LAMP_LOG_LAT   = 1;
    localparam int LAMP_LOG_OP_W  = 20;
    localparam int LAMP_LOG_RES_W = 19;

    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] f;
        logic       isZ;
        logic       isInf;
        logic       isSNAN;
        logic       isQNAN;
    } lampLogOp_t;

    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] f;
        logic       isOverflow;
        logic       isUnderflow;
        logic       isToRound;
    } lampLogRes_t;

endpackage

// File: rtl/lampfpu_log_rr_pick.sv
// lampfpu_log_rr_pick
// Combinational round-robin picker: rotates the eligibility vector so that
// rr_ptr_i becomes position 0, takes the lowest set bit, then rotates the
// one-hot back to requester numbering.
//   elig_i   : per-requester eligibility
//   rr_ptr_i : index with highest priority this cycle
//   gnt_o    : one-hot grant, all zero when nothing is eligible
module lampfpu_log_rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  elig_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [NREQ-1:0]  gnt_o
);

    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] pick;
    logic            found;

    always_comb begin
        rot   = '0;
        pick  = '0;
        gnt_o = '0;
        found = 1'b0;
        // rotated position j corresponds to requester (j + rr_ptr) mod NREQ
        for (int j = 0; j < NREQ; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == (j + int'(rr_ptr_i)) % NREQ) begin
                    rot[j] = elig_i[i];
                end
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (rot[j] && !found) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == (j + int'(rr_ptr_i)) % NREQ) begin
                    gnt_o[i] = gnt_o[i] | pick[j];
                end
            end
        end
    end

endmodule

// File: rtl/lampfpu_log_arb.sv
// lampfpu_log_arb
// Shares one bfloat16 log unit among NREQ requesters. Operands are accepted
// round-robin, issued one per cycle, tracked through the unit's fixed latency
// with a tag pipe, and returned to the owner through a one-entry buffer.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid_i/req_op_i    : operand offers per requester
//   req_ready_o             : combinational one-hot grant
//   res_valid_o/res_o       : buffered result per requester
//   res_ready_i             : result consumed
//   log_do_o/log_op_o       : issue port to lampFPU_log
//   log_valid_i/log_res_i   : return port from lampFPU_log
//   busy_o                  : anything in flight or buffered
//   err_o                   : sticky, unexpected or missing log_valid_i
module lampfpu_log_arb
    import lampfpu_log_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LOG_LAT = LAMP_LOG_LAT,
    parameter int OP_W    = LAMP_LOG_OP_W,
    parameter int RES_W   = LAMP_LOG_RES_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid_i,
    input  logic [NREQ-1:0][OP_W-1:0]  req_op_i,
    output logic [NREQ-1:0]            req_ready_o,
    output logic [NREQ-1:0]            res_valid_o,
    output logic [NREQ-1:0][RES_W-1:0] res_o,
    input  logic [NREQ-1:0]            res_ready_i,
    output logic                       log_do_o,
    output logic [OP_W-1:0]            log_op_o,
    input  logic                       log_valid_i,
    input  logic [RES_W-1:0]           log_res_i,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]                inflight_q, inflight_d;
    logic                           do_q, do_d;
    logic [OP_W-1:0]                op_q, op_d;
    logic [PTR_W-1:0]               idx_q, idx_d;
    logic [LOG_LAT-1:0]             tag_vld_q, tag_vld_d;
    logic [LOG_LAT-1:0][PTR_W-1:0]  tag_idx_q, tag_idx_d;
    logic [NREQ-1:0]                res_vld_q, res_vld_d;
    logic [NREQ-1:0][RES_W-1:0]     res_q, res_d;
    logic                           err_q, err_d;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  gnt_ok;
    logic [PTR_W-1:0] gnt_idx;
    logic             tail_vld;
    logic [PTR_W-1:0] tail_idx;

    // A requester with an op in flight or an unconsumed result may not issue,
    // which is what keeps the one-entry result buffer from overflowing.
    assign elig = req_valid_i & ~inflight_q & ~res_vld_q;

    lampfpu_log_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .elig_i   (elig),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (gnt)
    );

    // no handshake may complete while reset is held
    assign gnt_ok = rst ? '0 : gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_ok[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    assign tail_vld = tag_vld_q[LOG_LAT-1];
    assign tail_idx = tag_idx_q[LOG_LAT-1];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        inflight_d = inflight_q;
        do_d       = 1'b0;
        op_d       = op_q;
        idx_d      = idx_q;
        tag_vld_d  = tag_vld_q;
        tag_idx_d  = tag_idx_q;
        res_vld_d  = res_vld_q & ~res_ready_i;
        res_d      = res_q;
        err_d      = err_q;

        // capture: handshake -> issue register
        if (|gnt_ok) begin
            do_d                = 1'b1;
            op_d                = req_op_i[gnt_idx];
            idx_d               = gnt_idx;
            inflight_d[gnt_idx] = 1'b1;
            rr_ptr_d            = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end

        // issue -> tag pipe; the tag is loaded in the cycle log_do_o is high
        tag_vld_d[0] = do_q;
        tag_idx_d[0] = idx_q;
        for (int s = 1; s < LOG_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end

        // tag pipe tail -> result buffer
        if (log_valid_i && tail_vld) begin
            res_d[tail_idx]      = log_res_i;
            res_vld_d[tail_idx]  = 1'b1;
            inflight_d[tail_idx] = 1'b0;
        end else if (log_valid_i || tail_vld) begin
            // unit and tracker disagree; leave state alone and flag it
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            do_q       <= 1'b0;
            op_q       <= '0;
            idx_q      <= '0;
            tag_vld_q  <= '0;
            tag_idx_q  <= '0;
            res_vld_q  <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            do_q       <= do_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            tag_vld_q  <= tag_vld_d;
            tag_idx_q  <= tag_idx_d;
            res_vld_q  <= res_vld_d;
            res_q      <= res_d;
            err_q      <= err_d;
        end
    end

    assign req_ready_o = gnt_ok;
    assign res_valid_o = res_vld_q;
    assign res_o       = res_q;
    assign log_do_o    = do_q;
    assign log_op_o    = op_q;
    assign busy_o      = (|inflight_q) | (|res_vld_q);
    assign err_o       = err_q;

endmodule

// File: tb/tb_lampfpu_log_arb.sv
`timescale 1ns/1ps
module tb_lampfpu_log_arb;

    localparam int NR = 4;
    localparam int LA = 1;
    localparam int LB = 3;
    localparam int OW = 20;
    localparam int RW = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // instance A: LOG_LAT = 1, checked every cycle against the model
    logic [NR-1:0]         a_valid, a_ready, a_rv, a_rready;
    logic [NR-1:0][OW-1:0] a_op;
    logic [NR-1:0][RW-1:0] a_res;
    logic                  a_do, a_lv, a_busy, a_err, a_inj;
    logic [OW-1:0]         a_lop;
    logic [RW-1:0]         a_lres;

    // instance B: LOG_LAT = 3, routing test
    logic [NR-1:0]         b_valid, b_ready, b_rv, b_rready;
    logic [NR-1:0][OW-1:0] b_op;
    logic [NR-1:0][RW-1:0] b_res;
    logic                  b_do, b_lv, b_busy, b_err;
    logic [OW-1:0]         b_lop;
    logic [RW-1:0]         b_lres;

    lampfpu_log_arb #(.NREQ(NR), .LOG_LAT(LA), .OP_W(OW), .RES_W(RW)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid_i(a_valid), .req_op_i(a_op), .req_ready_o(a_ready),
        .res_valid_o(a_rv), .res_o(a_res), .res_ready_i(a_rready),
        .log_do_o(a_do), .log_op_o(a_lop), .log_valid_i(a_lv), .log_res_i(a_lres),
        .busy_o(a_busy), .err_o(a_err)
    );

    lampfpu_log_arb #(.NREQ(NR), .LOG_LAT(LB), .OP_W(OW), .RES_W(RW)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid_i(b_valid), .req_op_i(b_op), .req_ready_o(b_ready),
        .res_valid_o(b_rv), .res_o(b_res), .res_ready_i(b_rready),
        .log_do_o(b_do), .log_op_o(b_lop), .log_valid_i(b_lv), .log_res_i(b_lres),
        .busy_o(b_busy), .err_o(b_err)
    );

    function automatic logic [RW-1:0] stub_fn(input logic [OW-1:0] op);
        return op[RW-1:0] ^ 19'h1A345 ^ {{(RW-1){1'b0}}, op[OW-1]};
    endfunction

    // log unit stubs, sharing rst
    logic          a_sv;
    logic [RW-1:0] a_sres;
    always @(posedge clk) begin
        if (rst) begin
            a_sv   <= 1'b0;
            a_sres <= '0;
        end else begin
            a_sv   <= a_do;
            a_sres <= stub_fn(a_lop);
        end
    end
    assign a_lv   = a_sv | a_inj;
    assign a_lres = a_sres;

    logic [LB-1:0]         b_sv;
    logic [LB-1:0][RW-1:0] b_sres;
    always @(posedge clk) begin
        if (rst) begin
            b_sv   <= '0;
            b_sres <= '0;
        end else begin
            b_sv[0]   <= b_do;
            b_sres[0] <= b_lop[RW-1:0];
            for (int k = 1; k < LB; k++) begin
                b_sv[k]   <= b_sv[k-1];
                b_sres[k] <= b_sres[k-1];
            end
        end
    end
    assign b_lv   = b_sv[LB-1];
    assign b_lres = b_sres[LB-1];

    // checking
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // behavioural model of instance A
    int            cyc;
    int            m_ptr;
    bit [NR-1:0]   m_out;
    int            m_due [NR];
    logic [RW-1:0] m_res [NR];
    logic [RW-1:0] m_buf [NR];
    bit            m_do;
    logic [OW-1:0] m_op;
    bit            m_err;

    // observed values of the last cycle, for directed literal checks
    logic [NR-1:0]         obs_ready, obs_rv, obs_bready, obs_brv;
    logic [NR-1:0][RW-1:0] obs_res, obs_bres;
    logic                  obs_do, obs_busy, obs_err, obs_bbusy, obs_berr;
    logic [OW-1:0]         obs_lop;

    task automatic model_reset();
        m_ptr = 0;
        m_out = '0;
        m_do  = 1'b0;
        m_op  = '0;
        m_err = 1'b0;
        for (int i = 0; i < NR; i++) begin
            m_due[i] = 0;
            m_res[i] = '0;
            m_buf[i] = '0;
        end
    endtask

    task automatic cycle();
        logic [NR-1:0] er;
        logic [NR-1:0] erv;
        int            g;
        @(negedge clk);
        for (int i = 0; i < NR; i++)
            if (m_out[i] && cyc == m_due[i]) m_buf[i] = m_res[i];
        er = '0;
        g  = -1;
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (g < 0 && a_valid[i] && !m_out[i]) g = i;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        for (int i = 0; i < NR; i++) erv[i] = m_out[i] && (cyc >= m_due[i]);

        chk("req_ready", 64'(a_ready), 64'(er));
        chk("log_do", 64'(a_do), 64'(m_do));
        chk("log_op", 64'(a_lop), 64'(m_op));
        chk("res_valid", 64'(a_rv), 64'(erv));
        for (int i = 0; i < NR; i++) chk($sformatf("res_o[%0d]", i), 64'(a_res[i]), 64'(m_buf[i]));
        chk("busy", 64'(a_busy), 64'(|m_out));
        chk("err", 64'(a_err), 64'(m_err));

        obs_ready = a_ready;  obs_rv = a_rv;  obs_res = a_res;  obs_do = a_do;
        obs_lop = a_lop;  obs_busy = a_busy;  obs_err = a_err;
        obs_bready = b_ready;  obs_brv = b_rv;  obs_bres = b_res;
        obs_bbusy = b_busy;  obs_berr = b_err;

        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NR; i++)
                if (erv[i] && a_rready[i]) m_out[i] = 1'b0;
            m_do = (g >= 0);
            if (g >= 0) begin
                m_out[g] = 1'b1;
                m_due[g] = cyc + 2 + LA;
                m_res[g] = stub_fn(a_op[g]);
                m_op     = a_op[g];
                m_ptr    = (g + 1) % NR;
            end
            if (a_inj) m_err = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++)
            if (v[i]) r = (r < 0) ? i : 99;
        return r;
    endfunction

    task automatic drain();
        bit done;
        done    = 1'b0;
        a_valid = '0;
        a_rready = '1;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            if (!obs_busy) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [8];
        int gn, others, g2;
        bit seen;
        logic [RW-1:0] held;

        rst = 1'b1;  a_inj = 1'b0;
        a_valid = '0;  a_op = '0;  a_rready = '1;
        b_valid = '0;  b_op = '0;  b_rready = '1;
        cyc = 0;
        model_reset();

        // reset state
        cycle();
        cycle();
        chk("rst_ready", 64'(obs_ready), 64'(0));
        chk("rst_res_valid", 64'(obs_rv), 64'(0));
        chk("rst_log_do", 64'(obs_do), 64'(0));
        chk("rst_busy", 64'(obs_busy), 64'(0));
        rst = 1'b0;

        // single op from requester 0
        a_valid = 4'b0001;  a_op[0] = 20'h08000;  a_rready = '0;
        cycle();
        chk("single_grant", 64'(obs_ready), 64'(4'b0001));
        a_valid = '0;
        cycle();
        chk("single_do", 64'(obs_do), 64'(1));
        chk("single_op", 64'(obs_lop), 64'(20'h08000));
        cycle();
        chk("single_rv_early", 64'(obs_rv), 64'(0));
        cycle();
        chk("single_rv", 64'(obs_rv), 64'(4'b0001));
        chk("single_res", 64'(obs_res[0]), 64'(19'h12345));
        a_rready = '1;
        cycle();
        cycle();

        // round robin from a fresh pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        a_valid = '1;  a_rready = '1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) a_op[i] = 20'($urandom);
            cycle();
            seq[k] = oh_idx(obs_ready);
        end
        for (int k = 0; k < 8; k++) chk($sformatf("rr_seq[%0d]", k), 64'(seq[k]), 64'(k % 4));

        // back-pressure on requester 2
        a_rready = 4'b1011;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            for (int i = 0; i < NR; i++) a_op[i] = 20'($urandom);
            cycle();
            if (obs_rv[2]) seen = 1'b1;
        end
        if (!seen) chk("bp_wait_timeout", 64'(1), 64'(0));
        held = obs_res[2];
        others = 0;
        g2 = 0;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NR; i++) a_op[i] = 20'($urandom);
            cycle();
            chk("bp_res_stable", 64'(obs_res[2]), 64'(held));
            gn = oh_idx(obs_ready);
            if (gn == 2) g2++;
            else if (gn >= 0) others++;
        end
        chk("bp_no_grant_2", 64'(g2), 64'(0));
        chk("bp_others_granted", 64'(others >= 6), 64'(1));
        a_rready = '1;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NR; i++) begin
                a_op[i]     = 20'($urandom);
                a_valid[i]  = ($urandom_range(0, 2) != 0);
                a_rready[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        drain();

        // stray log_valid_i sets a sticky error
        a_inj = 1'b1;
        cycle();
        a_inj = 1'b0;
        cycle();
        chk("err_set", 64'(obs_err), 64'(1));
        for (int k = 0; k < 5; k++) cycle();
        chk("err_held", 64'(obs_err), 64'(1));
        chk("err_no_res", 64'(obs_rv), 64'(0));

        // reset one cycle after a handshake
        a_valid = 4'b0010;  a_op[1] = 20'($urandom);
        cycle();
        chk("mid_grant", 64'(oh_idx(obs_ready) >= 0), 64'(1));
        a_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("mid_ready", 64'(obs_ready), 64'(0));
        chk("mid_do", 64'(obs_do), 64'(0));
        chk("mid_op", 64'(obs_lop), 64'(0));
        chk("mid_rv", 64'(obs_rv), 64'(0));
        chk("mid_res", 64'(obs_res), 64'(0));
        chk("mid_busy", 64'(obs_busy), 64'(0));
        chk("mid_err", 64'(obs_err), 64'(0));
        cycle();
        cycle();
        chk("mid_no_stray_rv", 64'(obs_rv), 64'(0));
        chk("mid_no_stray_err", 64'(obs_err), 64'(0));

        // routing through LOG_LAT = 3
        b_rready = '0;
        b_valid = 4'b0010;  b_op[1] = 20'h1;
        cycle();
        chk("route_g1", 64'(obs_bready), 64'(4'b0010));
        b_valid = 4'b1000;  b_op[3] = 20'h3;
        cycle();
        chk("route_g3", 64'(obs_bready), 64'(4'b1000));
        b_valid = 4'b0001;  b_op[0] = 20'h0;
        cycle();
        chk("route_g0", 64'(obs_bready), 64'(4'b0001));
        b_valid = '0;
        cycle();
        cycle();
        chk("route_rv_t4", 64'(obs_brv), 64'(4'b0000));
        cycle();
        chk("route_rv_t5", 64'(obs_brv), 64'(4'b0010));
        cycle();
        chk("route_rv_t6", 64'(obs_brv), 64'(4'b1010));
        cycle();
        chk("route_rv_t7", 64'(obs_brv), 64'(4'b1011));
        chk("route_res1", 64'(obs_bres[1]), 64'(19'h1));
        chk("route_res3", 64'(obs_bres[3]), 64'(19'h3));
        chk("route_res0", 64'(obs_bres[0]), 64'(19'h0));
        chk("route_busy", 64'(obs_bbusy), 64'(1));
        chk("route_err", 64'(obs_berr), 64'(0));
        b_rready = '1;
        cycle();
        cycle();
        chk("route_drained", 64'(obs_bbusy), 64'(0));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
